// File: rtl/game_flow_if.sv
// game_flow_if
//   Bundles the frame/player event inputs and the status outputs of the game-flow
//   controller so they can be passed around as one port.
//   Inputs to the controller : fsync, ready_up, aliens_cleared, player_hit
//   Outputs of the controller: state, level, lives, alien_speed, aliens_reset,
//                              play_active, show_start, show_banner, game_over,
//                              use_gameover_pixels
//   modport master : the side that produces events and consumes status
//   modport slave  : the controller itself
interface game_flow_if #(
  parameter int LVL_W   = 5,
  parameter int LIVES_W = 3,
  parameter int SPEED_W = 4
);
  logic               fsync;
  logic               ready_up;
  logic               aliens_cleared;
  logic               player_hit;
  logic [2:0]         state;
  logic [LVL_W-1:0]   level;
  logic [LIVES_W-1:0] lives;
  logic [SPEED_W-1:0] alien_speed;
  logic               aliens_reset;
  logic               play_active;
  logic               show_start;
  logic               show_banner;
  logic               game_over;
  logic               use_gameover_pixels;

  modport master (
    output fsync, ready_up, aliens_cleared, player_hit,
    input  state, level, lives, alien_speed, aliens_reset, play_active,
           show_start, show_banner, game_over, use_gameover_pixels
  );

  modport slave (
    input  fsync, ready_up, aliens_cleared, player_hit,
    output state, level, lives, alien_speed, aliens_reset, play_active,
           show_start, show_banner, game_over, use_gameover_pixels
  );
endinterface

// File: rtl/game_flow_controller.sv
// game_flow_controller
//   Game-flow FSM for the shooter: START -> BANNER -> PLAY -> CLEAR -> BANNER ...
//   and PLAY -> GAMEOVER -> START. Tracks level, spare lives and alien speed.
//   All pause timers count frames (fsync pulses); the frame counter restarts on
//   every state change. All outputs come straight from flops.
// Ports:
//   pixel_clk : clock
//   rst       : synchronous reset, active-high
//   gf        : game_flow_if.slave (event inputs, state/level/lives/speed/flags)
// Build option:
//   GAME_FLOW_EXTRA_LIFE_EN - when defined, each CLEAR->BANNER transition into a
//   level that is a multiple of 4 grants one extra life (capped at LIVES_MAX).
module game_flow_controller #(
  parameter int MAX_LEVEL       = 16,
  parameter int LVL_W           = 5,
  parameter int LIVES_INIT      = 3,
  parameter int LIVES_MAX       = 7,
  parameter int LIVES_W         = 3,
  parameter int SPEED_W         = 4,
  parameter int SPEED_BASE      = 1,
  parameter int SPEED_STEP      = 1,
  parameter int SPEED_MAX       = 15,
  parameter int START_FRAMES    = 60,
  parameter int BANNER_FRAMES   = 120,
  parameter int CLEAR_FRAMES    = 90,
  parameter int GAMEOVER_FRAMES = 180
) (
  input  logic         pixel_clk,
  input  logic         rst,
  game_flow_if.slave   gf
);

  typedef enum logic [2:0] {
    ST_START    = 3'd0,
    ST_BANNER   = 3'd1,
    ST_PLAY     = 3'd2,
    ST_CLEAR    = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_e;

  localparam int MF_A       = (START_FRAMES > BANNER_FRAMES) ? START_FRAMES : BANNER_FRAMES;
  localparam int MF_B       = (CLEAR_FRAMES > GAMEOVER_FRAMES) ? CLEAR_FRAMES : GAMEOVER_FRAMES;
  localparam int MAX_FRAMES = (MF_A > MF_B) ? MF_A : MF_B;
  // One spare code above the longest wait so the saturated value never equals N-1.
  localparam int FC_W       = $clog2(MAX_FRAMES + 1);
  localparam int LIVES_START = (LIVES_INIT > LIVES_MAX) ? LIVES_MAX : LIVES_INIT;

  state_e             state_q, state_d;
  logic [FC_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic               start_ok_q, start_ok_d;   // START minimum dwell has elapsed
  logic [LVL_W-1:0]   level_q, level_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic               aliens_reset_q, aliens_reset_d;
  logic               play_active_q, play_active_d;
  logic               show_start_q, show_start_d;
  logic               show_banner_q, show_banner_d;
  logic               game_over_q, game_over_d;

  logic [FC_W-1:0]    last_cnt_s;
  logic               done_s;
  logic [LVL_W-1:0]   level_next_s;
  logic [SPEED_W:0]   speed_sum_s;

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d      = state_q;
    start_ok_d   = start_ok_q;
    level_d      = level_q;
    lives_d      = lives_q;
    speed_d      = speed_q;
    last_cnt_s   = {FC_W{1'b1}};
    level_next_s = level_q;
    speed_sum_s  = {1'b0, speed_q} + (SPEED_W+1)'(SPEED_STEP);

    case (state_q)
      ST_START:    last_cnt_s = FC_W'(START_FRAMES - 1);
      ST_BANNER:   last_cnt_s = FC_W'(BANNER_FRAMES - 1);
      ST_CLEAR:    last_cnt_s = FC_W'(CLEAR_FRAMES - 1);
      ST_GAMEOVER: last_cnt_s = FC_W'(GAMEOVER_FRAMES - 1);
      default:     last_cnt_s = {FC_W{1'b1}};
    endcase
    done_s = gf.fsync && (frame_cnt_q == last_cnt_s);

    if (level_q >= LVL_W'(MAX_LEVEL)) begin
      level_next_s = LVL_W'(MAX_LEVEL);
    end else begin
      level_next_s = level_q + LVL_W'(1);
    end

    case (state_q)
      ST_START: begin
        if (done_s) begin
          start_ok_d = 1'b1;
        end else begin
          start_ok_d = start_ok_q;
        end
        // ready_up is honoured on the same cycle the dwell completes.
        if ((start_ok_q || done_s) && gf.ready_up) begin
          state_d = ST_BANNER;
          level_d = LVL_W'(1);
          lives_d = LIVES_W'(LIVES_START);
          speed_d = SPEED_W'(SPEED_BASE);
        end else begin
          state_d = ST_START;
        end
      end
      ST_BANNER: begin
        if (done_s) begin
          state_d = ST_PLAY;
        end else begin
          state_d = ST_BANNER;
        end
      end
      ST_PLAY: begin
        // A hit is resolved before a simultaneous clear.
        if (gf.player_hit && (lives_q == '0)) begin
          state_d = ST_GAMEOVER;
        end else if (gf.player_hit) begin
          lives_d = lives_q - LIVES_W'(1);
          state_d = gf.aliens_cleared ? ST_CLEAR : ST_PLAY;
        end else if (gf.aliens_cleared) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_CLEAR: begin
        if (done_s) begin
          state_d = ST_BANNER;
          level_d = level_next_s;
          if (speed_sum_s > (SPEED_W+1)'(SPEED_MAX)) begin
            speed_d = SPEED_W'(SPEED_MAX);
          end else begin
            speed_d = speed_sum_s[SPEED_W-1:0];
          end
`ifdef GAME_FLOW_EXTRA_LIFE_EN
          if ((level_next_s[1:0] == 2'b00) && (lives_q < LIVES_W'(LIVES_MAX))) begin
            lives_d = lives_q + LIVES_W'(1);
          end else begin
            lives_d = lives_q;
          end
`endif
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_GAMEOVER: begin
        if (done_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_GAMEOVER;
        end
      end
      default: state_d = ST_START;
    endcase

    if (state_d != state_q) begin
      frame_cnt_d = '0;
      start_ok_d  = 1'b0;
    end else if (gf.fsync && (frame_cnt_q != {FC_W{1'b1}})) begin
      frame_cnt_d = frame_cnt_q + FC_W'(1);
    end else begin
      frame_cnt_d = frame_cnt_q;
    end

    aliens_reset_d = (state_d == ST_BANNER) && (state_q != ST_BANNER);
    play_active_d  = (state_d == ST_PLAY);
    show_start_d   = (state_d == ST_START);
    show_banner_d  = (state_d == ST_BANNER);
    game_over_d    = (state_d == ST_GAMEOVER);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q        <= ST_START;
      frame_cnt_q    <= '0;
      start_ok_q     <= 1'b0;
      level_q        <= '0;
      lives_q        <= '0;
      speed_q        <= '0;
      aliens_reset_q <= 1'b0;
      play_active_q  <= 1'b0;
      show_start_q   <= 1'b1;
      show_banner_q  <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_cnt_q    <= frame_cnt_d;
      start_ok_q     <= start_ok_d;
      level_q        <= level_d;
      lives_q        <= lives_d;
      speed_q        <= speed_d;
      aliens_reset_q <= aliens_reset_d;
      play_active_q  <= play_active_d;
      show_start_q   <= show_start_d;
      show_banner_q  <= show_banner_d;
      game_over_q    <= game_over_d;
    end
  end

  assign gf.state               = state_q;
  assign gf.level               = level_q;
  assign gf.lives               = lives_q;
  assign gf.alien_speed         = speed_q;
  assign gf.aliens_reset        = aliens_reset_q;
  assign gf.play_active         = play_active_q;
  assign gf.show_start          = show_start_q;
  assign gf.show_banner         = show_banner_q;
  assign gf.game_over           = game_over_q;
  assign gf.use_gameover_pixels = game_over_q;

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Parametrised game-flow FSM for the shooter; successor to the fixed 4-state controller.
- Sequences start screen, level banner, play, level-clear pause and game-over screen.
- Tracks level, lives and alien speed; all pause timers are counted in frames using fsync.
- Drives the alien and paddle blocks (aliens_reset, alien_speed, play_active) and the pixel mux (show_* flags).

Parameters:
MAX_LEVEL, 16, highest level; level saturates here
LVL_W, 5, width of level output
LIVES_INIT, 3, lives granted at game start
LIVES_MAX, 7, cap on lives (used by optional feature)
LIVES_W, 3, width of lives output
SPEED_W, 4, width of alien_speed
SPEED_BASE, 1, speed at level 1
SPEED_STEP, 1, speed increment per level
SPEED_MAX, 15, speed saturation value
START_FRAMES, 60, minimum frames on start screen before ready_up is honoured (>=1)
BANNER_FRAMES, 120, frames the level banner is shown (>=1)
CLEAR_FRAMES, 90, frames of pause after the level is cleared (>=1)
GAMEOVER_FRAMES, 180, frames the game-over screen is shown (>=1)

Ports:
pixel_clk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
fsync  in  1  one-cycle pulse at frame start
ready_up  in  1  player start request (level)
aliens_cleared  in  1  one-cycle pulse: last alien destroyed
player_hit  in  1  one-cycle pulse: paddle hit
state  out  3  encoded state: 0 START, 1 BANNER, 2 PLAY, 3 CLEAR, 4 GAMEOVER
level  out  LVL_W  current level
lives  out  LIVES_W  remaining spare lives
alien_speed  out  SPEED_W  alien step size for the current level
aliens_reset  out  1  one-cycle pulse on entry to BANNER
play_active  out  1  high in PLAY only
show_start  out  1  high in START
show_banner  out  1  high in BANNER
game_over  out  1  high in GAMEOVER
use_gameover_pixels  out  1  equals game_over

Behaviour:
- One clock domain (pixel_clk). Reset is synchronous and active-high (rst).
- All outputs are registered.
- Reset values: state=START, level=0, lives=0, alien_speed=0, frame_cnt=0, all flags 0 except show_start=1.
- frame_cnt clears on every state change and increments on fsync, saturating at its maximum.
- done(N) is true when fsync=1 and frame_cnt==N-1.
- A state change becomes visible on the cycle after the qualifying input cycle.
- START -> BANNER: requires done(START_FRAMES) to have occurred and ready_up=1.
  - ready_up is sampled every cycle after that; it does not need to align with fsync.
  - On this transition: level=1, lives=LIVES_INIT, alien_speed=SPEED_BASE.
- BANNER -> PLAY: on done(BANNER_FRAMES).
  - aliens_reset is high exactly the first cycle in BANNER.
- PLAY, player_hit=1:
  - If lives==0 -> GAMEOVER.
  - Otherwise lives decrements by 1 and the FSM stays in PLAY.
- PLAY, aliens_cleared=1 -> CLEAR.
- PLAY, player_hit and aliens_cleared in the same cycle:
  - The hit is evaluated first.
  - If the hit ends the game -> GAMEOVER.
  - Otherwise lives decrements and the FSM goes to CLEAR.
- CLEAR -> BANNER: on done(CLEAR_FRAMES).
  - On this transition: level=min(level+1, MAX_LEVEL), alien_speed=min(alien_speed+SPEED_STEP, SPEED_MAX).
  - The speed add is computed one bit wider and then saturated.
- GAMEOVER -> START: on done(GAMEOVER_FRAMES).
  - level, lives and alien_speed hold their last values until the next game start.
- player_hit and aliens_cleared are ignored outside PLAY. ready_up is ignored outside START.
- rst asserted in any state returns all state and outputs to reset values on the next clock edge; any pending pulse is dropped.
- Encodings 5–7 are unreachable; if entered, the FSM goes to START next cycle.

Optional Feature:
- Macro: GAME_FLOW_EXTRA_LIFE_EN.
- When defined: on the CLEAR -> BANNER transition, if the new level is a multiple of 4, lives increments by 1, saturating at LIVES_MAX.
- When undefined: lives never increases after game start.

Test Plan:
- Reset, then START_FRAMES=2, ready_up=1 from cycle 0 -> stays START until the 2nd fsync. Next cycle: state=1, level=1, lives=3, speed=1, aliens_reset high for 1 cycle.
- BANNER_FRAMES=2 -> after 2 fsyncs, state=2 and play_active=1. Four player_hit pulses: lives go 3,2,1,0, then state=4 with game_over=1 and use_gameover_pixels=1.
- In PLAY with lives=2, player_hit and aliens_cleared in the same cycle -> lives=1, state=3. After CLEAR_FRAMES fsyncs: level=2, speed=2, aliens_reset pulses.
- MAX_LEVEL=3, SPEED_MAX=2, clear 4 levels -> level sequence 1,2,3,3; speed sequence 1,2,2,2.
- rst pulsed mid-PLAY at level 2 -> next cycle state=0, level=0, lives=0, show_start=1. aliens_cleared in START has no effect.
- With GAME_FLOW_EXTRA_LIFE_EN defined and LIVES_INIT=7, clear level 3 -> level=4, lives stays 7 (saturated). With LIVES_INIT=3 -> lives=4.
